rx_l3_sequencer: RTL and testbench
==================================

Name: rx_l3_sequencer

Overview:
- Sits between the Ethernet MAC receive payload stream and the IPv4 header parser.
- Classifies each frame by EtherType and steers bytes to the IPv4 or ARP path.
- Validates version/IHL/total length/destination IP, strips Ethernet padding and issues a per-frame reset to the parser.
- Reports per-frame status and keeps saturating good/drop counters.

Parameters:
- ETH_IPV4, 16'h0800, EtherType routed to the IPv4 path
- ETH_ARP, 16'h0806, EtherType routed to the ARP path
- MAX_LEN, 16'd1500, largest accepted IPv4 total_len
- ACCEPT_BCAST, 1, 1 also accepts destination 255.255.255.255

Ports:
- RX_CLK  in  1  receive clock; all logic is on its rising edge
- rst  in  1  synchronous, active-high reset
- ip_addr  in  32  local IPv4 address, big-endian byte order
- rx_eth_valid  in  1  rx_eth_data holds a payload byte this cycle
- rx_eth_data  in  8  MAC payload byte (EtherType already stripped)
- rx_eth_type  in  16  EtherType; stable from first valid byte until rx_eth_end
- rx_eth_end  in  1  one-cycle pulse marking end of frame; may coincide with the last valid byte
- rx_eth_fcs_ok  in  1  FCS result; sampled only with rx_eth_end
- rx_payload_ipv4  out  1  rx_payload is an IPv4 byte for the parser
- rx_payload_arp  out  1  rx_payload is an ARP byte
- rx_payload  out  8  registered copy of rx_eth_data
- ipv4_rst  out  1  parser reset: rst OR internal one-cycle pulse
- ipv4_done  out  1  one-cycle pulse when an IPv4 frame finishes or aborts
- ipv4_ok  out  1  frame status; valid while ipv4_done=1
- ipv4_good_cnt  out  16  count of accepted frames, saturating at 16'hFFFF
- ipv4_drop_cnt  out  16  count of rejected IPv4 frames, saturating at 16'hFFFF

Behaviour:
- Reset values: every output is 0 except ipv4_rst=1. State is IDLE, counters are cleared.
- Latency: the registered outputs rx_payload, rx_payload_ipv4 and rx_payload_arp lag the input byte by exactly 1 cycle. Forwarding decisions are taken on the input byte, so a rejected byte is never forwarded.
- byte_cnt: 16 bits, counts valid IPv4 bytes from 0. hlen = IHL*4, taken from byte 0 low nibble. tlen is taken from bytes 2-3, big-endian.
- State IDLE, first valid byte, chosen by rx_eth_type:
  - ETH_ARP -> ARP.
  - ETH_IPV4 with byte[7:4]==4 and byte[3:0]>=5 -> FWD; byte 0 is forwarded.
  - ETH_IPV4 failing that check -> DROP; nothing is forwarded.
  - Any other EtherType -> SKIP.
- State FWD: forward each valid byte.
  - At byte 3: if tlen<hlen or tlen>MAX_LEN, byte 3 is not forwarded -> DROP.
  - Bytes 16-19: compare against ip_addr; if ACCEPT_BCAST=1, also against 8'hFF. Mismatch at byte 19 sets the reject flag; the byte is still forwarded and the parser is cleared by ipv4_rst.
  - When byte_cnt reaches tlen-1, forward that byte -> PAD.
- State PAD: swallow the remaining padding bytes.
- State ARP: assert rx_payload_arp for every valid byte.
- States DROP and SKIP: swallow bytes.
- Frame end: rx_eth_end in any non-IDLE state -> IDLE on the next cycle. A valid byte on the same cycle is processed first.
  - For IPv4 frames (FWD, PAD, DROP), the cycle after rx_eth_end pulses ipv4_done and ipv4_rst for 1 cycle, and increments exactly one counter.
  - ipv4_ok=1 only if all of: PAD was reached, dst matched, rx_eth_fcs_ok=1.
  - Ending in FWD (truncated frame) gives ipv4_ok=0.
  - ARP and SKIP frames do not pulse ipv4_done.
- rx_eth_end in IDLE is ignored; no pulses.
- Valid bytes in IDLE following an end of frame start a new frame. rx_eth_type is resampled at that point.
- rst mid-frame: back to IDLE. Outputs return to reset values on the next edge. No ipv4_done is generated.

Test Plan:
- Good frame: IPv4, hlen=20, tlen=28, dst=ip_addr=C0A80002, 46-byte payload with 18 pad bytes, fcs_ok=1 -> 28 bytes forwarded with 1-cycle lag, no pad forwarded; ipv4_done+ipv4_ok, ipv4_rst pulse, good_cnt=1.
- Bad version: byte0=8'h65 -> rx_payload_ipv4 never high; on end ipv4_done with ipv4_ok=0, drop_cnt=1.
- Bad length: tlen=16'd19 (below 20), then tlen=16'd1501 in a second frame -> forwarding stops after byte 2 in each; drop_cnt +2.
- Wrong dst: dst=C0A80003 -> all 28 bytes forwarded, ipv4_ok=0. Dst=FFFFFFFF with ACCEPT_BCAST=1 -> ipv4_ok=1.
- Truncated/FCS: rx_eth_end coinciding with byte 25 of tlen=28 -> byte 25 forwarded, ipv4_ok=0. Full frame with fcs_ok=0 -> ipv4_ok=0.
- ARP (EtherType 0x0806) then EtherType 0x86DD, with rst asserted mid-IPv4 frame -> ARP bytes carry rx_payload_arp only; 0x86DD frame is silent; after rst, outputs are at reset values and no ipv4_done; counter saturation is checked at 16'hFFFF.

Source files
------------

// File: rtl/rx_l3_sequencer.sv
// rx_l3_sequencer: sits between the MAC receive payload stream and the IPv4
// header parser. Classifies frames by EtherType, steers bytes to the IPv4 or
// ARP path, validates the IPv4 header fields that matter for forwarding,
// strips Ethernet padding and reports per-frame status with saturating
// good/drop counters.
module rx_l3_sequencer #(
   parameter logic [15:0] ETH_IPV4     = 16'h0800,
   parameter logic [15:0] ETH_ARP      = 16'h0806,
   parameter logic [15:0] MAX_LEN      = 16'd1500,
   parameter bit          ACCEPT_BCAST = 1'b1
) (
   input  logic        RX_CLK,
   input  logic        rst,
   input  logic [31:0] ip_addr,
   input  logic        rx_eth_valid,
   input  logic [7:0]  rx_eth_data,
   input  logic [15:0] rx_eth_type,
   input  logic        rx_eth_end,
   input  logic        rx_eth_fcs_ok,
   output logic        rx_payload_ipv4,
   output logic        rx_payload_arp,
   output logic [7:0]  rx_payload,
   output logic        ipv4_rst,
   output logic        ipv4_done,
   output logic        ipv4_ok,
   output logic [15:0] ipv4_good_cnt,
   output logic [15:0] ipv4_drop_cnt
);

   typedef enum logic [2:0] {
      StIdle,
      StFwd,
      StPad,
      StArp,
      StDrop,
      StSkip
   } state_e;

   state_e      state_q, state_d;
   // State after the current byte is processed, before frame-end handling.
   state_e      frame_state;

   logic [15:0] byte_cnt_q, byte_cnt_d;
   logic [5:0]  hlen_q, hlen_d;
   logic [15:0] tlen_q, tlen_d;
   logic [15:0] tlen_chk;
   logic        uc_match_q, uc_match_d;
   logic        bc_match_q, bc_match_d;
   logic        reject_q, reject_d;
   logic [7:0]  ip_byte;

   logic        fwd_ipv4, fwd_arp;
   logic [7:0]  payload_q;
   logic        pl_ipv4_q, pl_arp_q;

   logic        done_q, done_d;
   logic        ok_q, ok_d;
   logic        int_rst_q, int_rst_d;
   logic [15:0] good_q, good_d;
   logic [15:0] drop_q, drop_d;

   // Per-byte classification, header checks and frame-end handling.
   always_comb begin
      state_d     = state_q;
      frame_state = state_q;
      byte_cnt_d  = byte_cnt_q;
      hlen_d      = hlen_q;
      tlen_d      = tlen_q;
      tlen_chk    = 16'd0;
      uc_match_d  = uc_match_q;
      bc_match_d  = bc_match_q;
      reject_d    = reject_q;
      ip_byte     = 8'h00;
      fwd_ipv4    = 1'b0;
      fwd_arp     = 1'b0;
      done_d      = 1'b0;
      ok_d        = 1'b0;
      int_rst_d   = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (rx_eth_valid) begin
               byte_cnt_d = 16'd1;
               hlen_d     = {rx_eth_data[3:0], 2'b00};
               tlen_d     = 16'd0;
               uc_match_d = 1'b1;
               bc_match_d = ACCEPT_BCAST;
               reject_d   = 1'b0;
               if (rx_eth_type == ETH_ARP) begin
                  frame_state = StArp;
                  fwd_arp     = 1'b1;
               end else if (rx_eth_type == ETH_IPV4) begin
                  if (rx_eth_data[7:4] == 4'd4 && rx_eth_data[3:0] >= 4'd5) begin
                     frame_state = StFwd;
                     fwd_ipv4    = 1'b1;
                  end else begin
                     frame_state = StDrop;
                  end
               end else begin
                  frame_state = StSkip;
               end
            end
         end

         StFwd: begin
            if (rx_eth_valid) begin
               fwd_ipv4   = 1'b1;
               byte_cnt_d = byte_cnt_q + 16'd1;

               if (byte_cnt_q == 16'd2) begin
                  tlen_d = {rx_eth_data, 8'h00};
               end

               // Length check happens on the last length byte, so that byte is held back.
               if (byte_cnt_q == 16'd3) begin
                  tlen_chk = {tlen_q[15:8], rx_eth_data};
                  if (tlen_chk < {10'd0, hlen_q} || tlen_chk > MAX_LEN) begin
                     fwd_ipv4    = 1'b0;
                     frame_state = StDrop;
                  end else begin
                     tlen_d = tlen_chk;
                  end
               end

               // Unicast and broadcast matches are tracked separately so that a
               // mixed address such as C0.FF.00.02 is not accepted.
               if (byte_cnt_q >= 16'd16 && byte_cnt_q <= 16'd19) begin
                  unique case (byte_cnt_q[1:0])
                     2'd0:    ip_byte = ip_addr[31:24];
                     2'd1:    ip_byte = ip_addr[23:16];
                     2'd2:    ip_byte = ip_addr[15:8];
                     default: ip_byte = ip_addr[7:0];
                  endcase
                  uc_match_d = uc_match_q && (rx_eth_data == ip_byte);
                  bc_match_d = bc_match_q && (rx_eth_data == 8'hFF);
                  if (byte_cnt_q == 16'd19 && !(uc_match_d || bc_match_d)) begin
                     reject_d  = 1'b1;
                     int_rst_d = 1'b1;
                  end
               end

               if (byte_cnt_q >= 16'd4 && byte_cnt_q == tlen_q - 16'd1) begin
                  frame_state = StPad;
               end
            end
         end

         StArp: begin
            fwd_arp = rx_eth_valid;
         end

         default: begin
         end
      endcase

      state_d = frame_state;

      // A byte arriving with rx_eth_end in IDLE forms a one-byte frame, so end
      // is honoured whenever a frame is open after this cycle's byte.
      if (rx_eth_end && frame_state != StIdle) begin
         state_d = StIdle;
         if (frame_state == StFwd || frame_state == StPad || frame_state == StDrop) begin
            done_d    = 1'b1;
            int_rst_d = 1'b1;
            ok_d      = (frame_state == StPad) && !reject_d && rx_eth_fcs_ok;
         end
      end
   end

   // Saturating good/drop counter next-state.
   always_comb begin
      good_d = good_q;
      drop_d = drop_q;
      if (done_d) begin
         if (ok_d) begin
            if (good_q != 16'hFFFF) good_d = good_q + 16'd1;
         end else begin
            if (drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
         end
      end
   end

   // State, header tracking and registered outputs.
   always_ff @(posedge RX_CLK) begin
      if (rst) begin
         state_q    <= StIdle;
         byte_cnt_q <= 16'd0;
         hlen_q     <= 6'd0;
         tlen_q     <= 16'd0;
         uc_match_q <= 1'b0;
         bc_match_q <= 1'b0;
         reject_q   <= 1'b0;
         payload_q  <= 8'h00;
         pl_ipv4_q  <= 1'b0;
         pl_arp_q   <= 1'b0;
         done_q     <= 1'b0;
         ok_q       <= 1'b0;
         int_rst_q  <= 1'b0;
         good_q     <= 16'd0;
         drop_q     <= 16'd0;
      end else begin
         state_q    <= state_d;
         byte_cnt_q <= byte_cnt_d;
         hlen_q     <= hlen_d;
         tlen_q     <= tlen_d;
         uc_match_q <= uc_match_d;
         bc_match_q <= bc_match_d;
         reject_q   <= reject_d;
         payload_q  <= rx_eth_data;
         pl_ipv4_q  <= fwd_ipv4;
         pl_arp_q   <= fwd_arp;
         done_q     <= done_d;
         ok_q       <= ok_d;
         int_rst_q  <= int_rst_d;
         good_q     <= good_d;
         drop_q     <= drop_d;
      end
   end

   assign rx_payload      = payload_q;
   assign rx_payload_ipv4 = pl_ipv4_q;
   assign rx_payload_arp  = pl_arp_q;
   assign ipv4_rst        = rst | int_rst_q;
   assign ipv4_done       = done_q;
   assign ipv4_ok         = ok_q;
   assign ipv4_good_cnt   = good_q;
   assign ipv4_drop_cnt   = drop_q;

endmodule

// File: tb/tb_rx_l3_sequencer.sv
// Scoreboard bench for rx_l3_sequencer: a frame-level reference model pushes
// expected forwarded bytes and frame status into queues; a monitor pops them.
module tb_rx_l3_sequencer;

   localparam logic [31:0] MY_IP = 32'hC0A80002;

   logic        RX_CLK = 1'b0;
   logic        rst;
   logic [31:0] ip_addr;
   logic        rx_eth_valid;
   logic [7:0]  rx_eth_data;
   logic [15:0] rx_eth_type;
   logic        rx_eth_end;
   logic        rx_eth_fcs_ok;
   logic        rx_payload_ipv4;
   logic        rx_payload_arp;
   logic [7:0]  rx_payload;
   logic        ipv4_rst;
   logic        ipv4_done;
   logic        ipv4_ok;
   logic [15:0] ipv4_good_cnt;
   logic [15:0] ipv4_drop_cnt;

   rx_l3_sequencer dut (
      .RX_CLK          (RX_CLK),
      .rst             (rst),
      .ip_addr         (ip_addr),
      .rx_eth_valid    (rx_eth_valid),
      .rx_eth_data     (rx_eth_data),
      .rx_eth_type     (rx_eth_type),
      .rx_eth_end      (rx_eth_end),
      .rx_eth_fcs_ok   (rx_eth_fcs_ok),
      .rx_payload_ipv4 (rx_payload_ipv4),
      .rx_payload_arp  (rx_payload_arp),
      .rx_payload      (rx_payload),
      .ipv4_rst        (ipv4_rst),
      .ipv4_done       (ipv4_done),
      .ipv4_ok         (ipv4_ok),
      .ipv4_good_cnt   (ipv4_good_cnt),
      .ipv4_drop_cnt   (ipv4_drop_cnt)
   );

   always #5 RX_CLK = ~RX_CLK;

   typedef struct {
      bit          ok;
      logic [15:0] good;
      logic [15:0] drop;
   } done_t;

   int          nvec = 0;
   int          nerr = 0;
   logic [7:0]  exp_ipv4_q[$];
   logic [7:0]  exp_arp_q[$];
   done_t       exp_done_q[$];
   logic [15:0] m_good;
   logic [15:0] m_drop;
   logic [7:0]  frm[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      nvec++;
      if (act !== req) begin
         nerr++;
         $display("FAIL %s: got %h, required %h", name, act, req);
      end
   endtask

   task automatic cycle();
      @(posedge RX_CLK);
      #1;
   endtask

   // Frame-level reference: what the parser should see for the bytes in frm.
   task automatic model_frame(input logic [15:0] etype, input bit fcs);
      int          n;
      int          nf;
      int          hlen;
      int          tlen;
      bit          ok;
      logic [7:0]  b0;
      logic [31:0] dst;
      done_t       d;
      n  = frm.size();
      nf = 0;
      ok = 1'b0;
      if (etype == 16'h0806) begin
         foreach (frm[i]) exp_arp_q.push_back(frm[i]);
      end else if (etype == 16'h0800) begin
         b0 = frm[0];
         if (b0[7:4] == 4'd4 && b0[3:0] >= 4'd5) begin
            hlen = int'(b0[3:0]) * 4;
            if (n < 4) begin
               nf = n;
            end else begin
               tlen = int'({frm[2], frm[3]});
               if (tlen < hlen || tlen > 1500) begin
                  nf = 3;
               end else begin
                  nf  = (n < tlen) ? n : tlen;
                  dst = (n >= 20) ? {frm[16], frm[17], frm[18], frm[19]} : 32'h0;
                  ok  = (n >= tlen) && (dst == MY_IP || dst == 32'hFFFFFFFF) && fcs;
               end
            end
         end
         for (int i = 0; i < nf; i++) exp_ipv4_q.push_back(frm[i]);
         if (ok) begin
            if (m_good != 16'hFFFF) m_good = m_good + 16'd1;
         end else begin
            if (m_drop != 16'hFFFF) m_drop = m_drop + 16'd1;
         end
         d.ok   = ok;
         d.good = m_good;
         d.drop = m_drop;
         exp_done_q.push_back(d);
      end
   endtask

   task automatic build_ipv4(input logic [7:0] b0, input logic [15:0] tlen,
                             input logic [31:0] dst, input int len);
      logic [7:0]  b;
      logic [31:0] sh;
      frm.delete();
      for (int i = 0; i < len; i++) begin
         b = 8'($urandom);
         if (i == 0) b = b0;
         if (i == 2) b = tlen[15:8];
         if (i == 3) b = tlen[7:0];
         if (i >= 16 && i <= 19) begin
            sh = dst >> (8 * (19 - i));
            b  = sh[7:0];
         end
         frm.push_back(b);
      end
   endtask

   task automatic build_raw(input int len);
      frm.delete();
      for (int i = 0; i < len; i++) frm.push_back(8'($urandom));
   endtask

   // end_late=0: rx_eth_end coincides with the last byte; 1: one cycle later.
   task automatic send_frame(input logic [15:0] etype, input bit fcs, input bit end_late,
                             input bit gaps);
      int last;
      model_frame(etype, fcs);
      rx_eth_type = etype;
      last = frm.size() - 1;
      foreach (frm[i]) begin
         if (gaps) begin
            repeat ($urandom_range(0, 1)) begin
               rx_eth_valid = 1'b0;
               rx_eth_end   = 1'b0;
               cycle();
            end
         end
         rx_eth_valid  = 1'b1;
         rx_eth_data   = frm[i];
         rx_eth_end    = (i == last) && !end_late;
         rx_eth_fcs_ok = rx_eth_end ? fcs : !fcs;
         cycle();
      end
      rx_eth_valid = 1'b0;
      rx_eth_end   = 1'b0;
      if (end_late) begin
         rx_eth_end    = 1'b1;
         rx_eth_fcs_ok = fcs;
         cycle();
         rx_eth_end = 1'b0;
      end
      repeat (2) cycle();
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_ipv4_rst"}, ipv4_rst, 1'b1);
      check({tag, "_pl_ipv4"}, rx_payload_ipv4, 1'b0);
      check({tag, "_pl_arp"}, rx_payload_arp, 1'b0);
      check({tag, "_payload"}, rx_payload, 8'h00);
      check({tag, "_done"}, ipv4_done, 1'b0);
      check({tag, "_ok"}, ipv4_ok, 1'b0);
      check({tag, "_good_cnt"}, ipv4_good_cnt, 16'h0);
      check({tag, "_drop_cnt"}, ipv4_drop_cnt, 16'h0);
   endtask

   // Monitor: every presented output must match the head of its queue.
   always @(negedge RX_CLK) begin
      if (!rst) begin
         if (rx_payload_ipv4 && rx_payload_arp) check("both_paths", 1'b1, 1'b0);
         if (rx_payload_ipv4) begin
            if (exp_ipv4_q.size() == 0) begin
               nvec++;
               nerr++;
               $display("FAIL unexpected_ipv4_byte: got %h, required none", rx_payload);
            end else begin
               check("ipv4_byte", rx_payload, exp_ipv4_q.pop_front());
            end
         end
         if (rx_payload_arp) begin
            if (exp_arp_q.size() == 0) begin
               nvec++;
               nerr++;
               $display("FAIL unexpected_arp_byte: got %h, required none", rx_payload);
            end else begin
               check("arp_byte", rx_payload, exp_arp_q.pop_front());
            end
         end
         if (ipv4_done) begin
            if (exp_done_q.size() == 0) begin
               nvec++;
               nerr++;
               $display("FAIL unexpected_done: got ipv4_done=1, required 0");
            end else begin
               done_t e;
               e = exp_done_q.pop_front();
               check("ipv4_ok", ipv4_ok, e.ok);
               check("good_cnt", ipv4_good_cnt, e.good);
               check("drop_cnt", ipv4_drop_cnt, e.drop);
               check("done_rst_pulse", ipv4_rst, 1'b1);
            end
         end
      end
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: got timeout, required completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int          sel;
      int          ihl;
      int          hlen;
      int          tlen;
      int          len;
      bit          fcs;
      bit          late;
      bit          tlen_ok;
      logic [3:0]  ver;
      logic [31:0] dst;
      logic [15:0] etype;

      rst           = 1'b1;
      ip_addr       = MY_IP;
      rx_eth_valid  = 1'b0;
      rx_eth_data   = 8'h00;
      rx_eth_type   = 16'h0000;
      rx_eth_end    = 1'b0;
      rx_eth_fcs_ok = 1'b0;
      m_good        = 16'd0;
      m_drop        = 16'd0;

      repeat (3) @(posedge RX_CLK);
      @(negedge RX_CLK);
      check_reset_outputs("reset");
      @(posedge RX_CLK);
      #1 rst = 1'b0;
      @(negedge RX_CLK);
      check("ipv4_rst_release", ipv4_rst, 1'b0);
      cycle();

      // Good frame: tlen 28, 46 bytes on the wire.
      build_ipv4(8'h45, 16'd28, MY_IP, 46);
      send_frame(16'h0800, 1'b1, 1'b0, 1'b0);
      // Bad version.
      build_ipv4(8'h65, 16'd28, MY_IP, 46);
      send_frame(16'h0800, 1'b1, 1'b0, 1'b0);
      // Total length below header length, then above MAX_LEN.
      build_ipv4(8'h45, 16'd19, MY_IP, 46);
      send_frame(16'h0800, 1'b1, 1'b1, 1'b0);
      build_ipv4(8'h45, 16'd1501, MY_IP, 46);
      send_frame(16'h0800, 1'b1, 1'b0, 1'b0);
      // Wrong destination, then broadcast.
      build_ipv4(8'h45, 16'd28, 32'hC0A80003, 46);
      send_frame(16'h0800, 1'b1, 1'b0, 1'b0);
      build_ipv4(8'h45, 16'd28, 32'hFFFFFFFF, 46);
      send_frame(16'h0800, 1'b1, 1'b1, 1'b0);
      // Truncated at byte 25, then FCS failure.
      build_ipv4(8'h45, 16'd28, MY_IP, 26);
      send_frame(16'h0800, 1'b1, 1'b0, 1'b0);
      build_ipv4(8'h45, 16'd28, MY_IP, 46);
      send_frame(16'h0800, 1'b0, 1'b0, 1'b0);
      // ARP, then an IPv6 frame that must stay silent.
      build_raw(28);
      send_frame(16'h0806, 1'b1, 1'b0, 1'b0);
      build_raw(40);
      send_frame(16'h86DD, 1'b1, 1'b0, 1'b0);
      // Stray end pulse in IDLE.
      rx_eth_end = 1'b1;
      cycle();
      rx_eth_end = 1'b0;
      repeat (2) cycle();

      // Randomized frames.
      for (int r = 0; r < 40; r++) begin
         sel  = $urandom_range(0, 9);
         fcs  = ($urandom_range(0, 3) != 0);
         late = 1'($urandom_range(0, 1));
         if (sel <= 6 || sel == 9) begin
            ihl = (sel == 0) ? $urandom_range(0, 4) : $urandom_range(5, 7);
            if (sel == 9) ihl = 5;
            ver  = (sel == 1) ? 4'h6 : 4'h4;
            hlen = ihl * 4;
            tlen_ok = 1'b0;
            if (ihl < 5) begin
               tlen = 40;
            end else if (sel == 2) begin
               tlen = ($urandom_range(0, 1) != 0) ? $urandom_range(0, hlen - 1)
                                                  : $urandom_range(1501, 2000);
            end else begin
               tlen    = $urandom_range(hlen, 80);
               tlen_ok = 1'b1;
            end
            case ($urandom_range(0, 3))
               0:       dst = 32'hFFFFFFFF;
               1:       dst = MY_IP ^ (32'h1 << $urandom_range(0, 31));
               default: dst = MY_IP;
            endcase
            if (sel == 9) dst = MY_IP;
            len = (tlen_ok && tlen > 46) ? tlen : 46;
            if (sel == 3) len = $urandom_range(1, len - 1);
            build_ipv4({ver, 4'(ihl)}, 16'(tlen), dst, len);
            send_frame(16'h0800, fcs, late, 1'b1);
         end else begin
            etype = (sel == 7) ? 16'h0806 : (($urandom_range(0, 1) != 0) ? 16'h86DD : 16'h8100);
            build_raw($urandom_range(20, 48));
            send_frame(etype, fcs, late, 1'b1);
         end
      end

      // Reset in the middle of a good IPv4 frame: ten bytes forwarded, no status.
      build_ipv4(8'h45, 16'd28, MY_IP, 46);
      rx_eth_type = 16'h0800;
      for (int i = 0; i < 10; i++) begin
         exp_ipv4_q.push_back(frm[i]);
         rx_eth_valid = 1'b1;
         rx_eth_data  = frm[i];
         cycle();
      end
      rx_eth_valid = 1'b0;
      cycle();
      rst = 1'b1;
      cycle();
      check_reset_outputs("midframe_rst");
      cycle();
      rst    = 1'b0;
      m_good = 16'd0;
      m_drop = 16'd0;
      cycle();
      check("post_rst_ipv4_rst", ipv4_rst, 1'b0);
      check("post_rst_done", ipv4_done, 1'b0);
      check("post_rst_pl_ipv4", rx_payload_ipv4, 1'b0);

      // Drop counter saturation: back-to-back one-byte bad-version frames.
      rx_eth_type = 16'h0800;
      for (int i = 0; i < 65540; i++) begin
         frm.delete();
         frm.push_back(8'h65);
         model_frame(16'h0800, 1'b0);
         rx_eth_valid  = 1'b1;
         rx_eth_data   = 8'h65;
         rx_eth_end    = 1'b1;
         rx_eth_fcs_ok = 1'b0;
         cycle();
      end
      rx_eth_valid = 1'b0;
      rx_eth_end   = 1'b0;
      repeat (2) cycle();
      check("drop_saturated", ipv4_drop_cnt, 16'hFFFF);
      check("good_after_sat", ipv4_good_cnt, 16'h0000);

      for (int i = 0; i < 50; i++) begin
         if (exp_ipv4_q.size() == 0 && exp_arp_q.size() == 0 && exp_done_q.size() == 0) break;
         cycle();
      end
      check("ipv4_q_drained", exp_ipv4_q.size(), 0);
      check("arp_q_drained", exp_arp_q.size(), 0);
      check("done_q_drained", exp_done_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
